fetch_sequencer: RTL and testbench

//  Program-counter sequencer for the 9-bit-instruction core. Drives current_pc into the

---
 rtl/fetch_sequencer.sv | 108 ++++++++++
 tb/tb_fetch_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Program-counter sequencer for the 9-bit-instruction core: steps, branches, stalls, halts, faults.
// Optional perf counters (cycle_count, retired_count) are built when FETCH_PERF_COUNT_EN is defined.
module fetch_sequencer #(
  parameter int              PC_W      = 32,
  parameter logic [PC_W-1:0] START_PC  = '0,
  parameter int              MEM_DEPTH = 4096,
  parameter logic [8:0]      HALT_INSN = 9'b111111111
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic [8:0]      instruction,
  output logic [PC_W-1:0] current_pc,
  output logic            fetch_valid,
  output logic            busy,
  output logic            done,
  output logic            fault
`ifdef FETCH_PERF_COUNT_EN
  ,
  output logic [31:0]     cycle_count,
  output logic [31:0]     retired_count
`endif
);

  // state | meaning
  // IDLE  | waiting for start, pc parked at START_PC
  // RUN   | fetching, pc advances each non-stalled cycle
  // HALT  | HALT_INSN seen, pc frozen until restart
  // FAULT | pc would leave memory, pc frozen until restart
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] HALT  = 2'd2;
  localparam logic [1:0] FAULT = 2'd3;

  // One extra bit so a depth equal to 2**PC_W still compares correctly.
  localparam logic [PC_W:0]   DEPTH   = (PC_W+1)'(MEM_DEPTH);
  localparam logic [PC_W-1:0] LAST_PC = PC_W'(MEM_DEPTH - 1);

  logic [1:0]      state, state_nxt;
  logic [PC_W-1:0] pc_nxt;
  logic            done_nxt;

  always_comb begin
    state_nxt = state;
    pc_nxt    = current_pc;
    done_nxt  = 1'b0;
    case (state)
      RUN: begin
        if (!stall) begin
          if (instruction == HALT_INSN) begin
            state_nxt = HALT;
            done_nxt  = 1'b1;
          end else if (branch_taken) begin
            if ({1'b0, branch_target} >= DEPTH) state_nxt = FAULT;
            else                                pc_nxt    = branch_target;
          end else if (current_pc == LAST_PC) begin
            state_nxt = FAULT;
          end else begin
            pc_nxt = current_pc + PC_W'(1);
          end
        end
      end
      IDLE, HALT, FAULT: begin
        if (start) begin
          state_nxt = RUN;
          pc_nxt    = START_PC;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      current_pc <= START_PC;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      current_pc <= pc_nxt;
      done       <= done_nxt;
    end
  end

  assign busy        = (state == RUN);
  assign fetch_valid = (state == RUN) && !stall;
  assign fault       = (state == FAULT);

`ifdef FETCH_PERF_COUNT_EN
  // Start only restarts the counters when it actually launches a run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_count   <= '0;
      retired_count <= '0;
    end else if (start && state != RUN) begin
      cycle_count   <= '0;
      retired_count <= '0;
    end else if (state == RUN) begin
      if (cycle_count != 32'hFFFF_FFFF) cycle_count <= cycle_count + 32'd1;
      if (!stall && retired_count != 32'hFFFF_FFFF) retired_count <= retired_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus random stimulus vs a rule-level model.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0, stall = 1'b0, branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic [8:0]  instruction = '0;
  logic [31:0] current_pc;
  logic        fetch_valid, busy, done, fault;

  logic        s_start = 1'b0, s_stall = 1'b0, s_bt = 1'b0;
  logic [31:0] s_tgt = '0;
  logic [8:0]  s_ins = '0;
  logic [31:0] s_pc;
  logic        s_fv, s_busy, s_done, s_fault;

`ifdef FETCH_PERF_COUNT_EN
  logic [31:0] cycle_count, retired_count, s_cyc, s_ret;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .instruction(instruction), .current_pc(current_pc),
    .fetch_valid(fetch_valid), .busy(busy), .done(done), .fault(fault)
`ifdef FETCH_PERF_COUNT_EN
    , .cycle_count(cycle_count), .retired_count(retired_count)
`endif
  );

  fetch_sequencer #(.MEM_DEPTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(s_start), .stall(s_stall),
    .branch_taken(s_bt), .branch_target(s_tgt),
    .instruction(s_ins), .current_pc(s_pc),
    .fetch_valid(s_fv), .busy(s_busy), .done(s_done), .fault(s_fault)
`ifdef FETCH_PERF_COUNT_EN
    , .cycle_count(s_cyc), .retired_count(s_ret)
`endif
  );

  // Reference model for the default-depth instance, written from the run-control rules.
  localparam longint DEPTH = 4096;
  bit          m_running, m_halted, m_faulted, m_done;
  logic [31:0] m_pc;
  longint      m_cyc, m_ret;

  task automatic model_reset();
    m_running = 0; m_halted = 0; m_faulted = 0; m_done = 0;
    m_pc = 0; m_cyc = 0; m_ret = 0;
  endtask

  task automatic model_edge();
    bit done_n = 0;
    if (m_running) begin
      if (m_cyc < 64'hFFFF_FFFF) m_cyc++;
      if (!stall && m_ret < 64'hFFFF_FFFF) m_ret++;
      if (stall) begin
      end else if (instruction == 9'h1FF) begin
        m_running = 0; m_halted = 1; done_n = 1;
      end else if (branch_taken) begin
        if (longint'(branch_target) >= DEPTH) begin m_running = 0; m_faulted = 1; end
        else m_pc = branch_target;
      end else if (longint'(m_pc) == DEPTH - 1) begin
        m_running = 0; m_faulted = 1;
      end else begin
        m_pc = m_pc + 1;
      end
    end else if (start) begin
      m_running = 1; m_halted = 0; m_faulted = 0;
      m_pc = 0; m_cyc = 0; m_ret = 0;
    end
    m_done = done_n;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start = 0; stall = 0; branch_taken = 0; branch_target = 0; instruction = 0;
    s_start = 0; s_stall = 0; s_bt = 0; s_tgt = 0; s_ins = 0;
  endtask

  // Called just after a rising edge: reset pulse well clear of the next edge, then start.
  task automatic restart();
    clear_inputs();
    reset = 0; #2; reset = 1;
    start = 1; tick(); start = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 0;
    #1;
    checks++; if (current_pc !== 32'd0) begin errors++; $display("FAIL reset_pc got=%0h exp=0", current_pc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0 || fault !== 1'b0) begin errors++; $display("FAIL reset_done_fault got=%b%b exp=00", done, fault); end
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_fetch_valid got=%b exp=0", fetch_valid); end
    tick(); tick();
    checks++; if (current_pc !== 32'd0 || busy !== 1'b0) begin errors++; $display("FAIL reset_hold pc=%0h busy=%b exp pc=0 busy=0", current_pc, busy); end
    reset = 1;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_no_start busy=%b exp=0", busy); end
  endtask

  task automatic test_increment();
    restart();
    for (int i = 0; i < 5; i++) begin
      checks++; if (current_pc !== 32'(i) || busy !== 1'b1 || fetch_valid !== 1'b1) begin
        errors++; $display("FAIL increment pc=%0h busy=%b fv=%b exp pc=%0h busy=1 fv=1", current_pc, busy, fetch_valid, i);
      end
      tick();
    end
  endtask

  task automatic test_branch();
    restart();
    tick(); tick(); tick();
    checks++; if (current_pc !== 32'd3) begin errors++; $display("FAIL branch_pre pc=%0h exp=3", current_pc); end
    branch_taken = 1; branch_target = 32'h20;
    tick();
    branch_taken = 0;
    checks++; if (current_pc !== 32'h20) begin errors++; $display("FAIL branch_taken pc=%0h exp=20", current_pc); end
    tick();
    checks++; if (current_pc !== 32'h21) begin errors++; $display("FAIL branch_then_inc pc=%0h exp=21", current_pc); end
  endtask

  task automatic test_stall();
    restart();
    repeat (5) tick();
    stall = 1; branch_taken = 1; branch_target = 32'h40;
    #1;
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL stall_fv got=%b exp=0", fetch_valid); end
    tick(); tick();
    checks++; if (current_pc !== 32'd5 || busy !== 1'b1) begin errors++; $display("FAIL stall_hold pc=%0h busy=%b exp pc=5 busy=1", current_pc, busy); end
    stall = 0; branch_taken = 0;
    #1;
    checks++; if (fetch_valid !== 1'b1) begin errors++; $display("FAIL unstall_fv got=%b exp=1", fetch_valid); end
    tick();
    checks++; if (current_pc !== 32'd6) begin errors++; $display("FAIL unstall_pc pc=%0h exp=6", current_pc); end
  endtask

  task automatic test_halt();
    restart();
    repeat (7) tick();
    instruction = 9'h1FF;
    tick();
    instruction = 0;
    checks++; if (done !== 1'b1 || current_pc !== 32'd7 || busy !== 1'b0) begin
      errors++; $display("FAIL halt_entry done=%b pc=%0h busy=%b exp done=1 pc=7 busy=0", done, current_pc, busy);
    end
    tick();
    checks++; if (done !== 1'b0 || current_pc !== 32'd7 || fault !== 1'b0) begin
      errors++; $display("FAIL halt_hold done=%b pc=%0h fault=%b exp done=0 pc=7 fault=0", done, current_pc, fault);
    end
    start = 1; tick(); start = 0;
    checks++; if (current_pc !== 32'd0 || busy !== 1'b1) begin errors++; $display("FAIL halt_restart pc=%0h busy=%b exp pc=0 busy=1", current_pc, busy); end
  endtask

  task automatic test_fault();
    clear_inputs();
    reset = 0; #2; reset = 1;
    s_start = 1; tick(); s_start = 0;
    repeat (15) tick();
    checks++; if (s_pc !== 32'd15 || s_fault !== 1'b0) begin errors++; $display("FAIL fault_pre pc=%0h fault=%b exp pc=f fault=0", s_pc, s_fault); end
    tick();
    checks++; if (s_fault !== 1'b1 || s_pc !== 32'd15 || s_busy !== 1'b0) begin
      errors++; $display("FAIL fault_wrap fault=%b pc=%0h busy=%b exp fault=1 pc=f busy=0", s_fault, s_pc, s_busy);
    end
    tick();
    checks++; if (s_fault !== 1'b1 || s_done !== 1'b0 || s_pc !== 32'd15) begin
      errors++; $display("FAIL fault_hold fault=%b done=%b pc=%0h exp fault=1 done=0 pc=f", s_fault, s_done, s_pc);
    end
    s_start = 1; tick(); s_start = 0;
    checks++; if (s_fault !== 1'b0 || s_pc !== 32'd0 || s_busy !== 1'b1) begin
      errors++; $display("FAIL fault_restart fault=%b pc=%0h busy=%b exp fault=0 pc=0 busy=1", s_fault, s_pc, s_busy);
    end
    s_bt = 1; s_tgt = 32'd15;
    tick();
    checks++; if (s_pc !== 32'd15 || s_fault !== 1'b0) begin errors++; $display("FAIL branch_last pc=%0h fault=%b exp pc=f fault=0", s_pc, s_fault); end
    s_tgt = 32'd16;
    tick();
    s_bt = 0;
    checks++; if (s_fault !== 1'b1 || s_pc !== 32'd15) begin errors++; $display("FAIL branch_oob fault=%b pc=%0h exp fault=1 pc=f", s_fault, s_pc); end
  endtask

  task automatic test_reset_midrun();
    restart();
    for (int i = 0; i < 10; i++) begin
      stall = (i == 3 || i == 4);
      tick();
    end
    stall = 0;
    checks++; if (current_pc !== 32'd8) begin errors++; $display("FAIL perf_run_pc pc=%0h exp=8", current_pc); end
`ifdef FETCH_PERF_COUNT_EN
    checks++; if (cycle_count !== 32'd10) begin errors++; $display("FAIL perf_cycle got=%0d exp=10", cycle_count); end
    checks++; if (retired_count !== 32'd8) begin errors++; $display("FAIL perf_retired got=%0d exp=8", retired_count); end
`endif
    tick();
    #2;
    reset = 0;
    #1;
    checks++; if (current_pc !== 32'd0 || busy !== 1'b0 || fetch_valid !== 1'b0) begin
      errors++; $display("FAIL async_reset pc=%0h busy=%b fv=%b exp pc=0 busy=0 fv=0", current_pc, busy, fetch_valid);
    end
`ifdef FETCH_PERF_COUNT_EN
    checks++; if (cycle_count !== 32'd0 || retired_count !== 32'd0) begin
      errors++; $display("FAIL perf_reset cyc=%0d ret=%0d exp 0 0", cycle_count, retired_count);
    end
`endif
    @(negedge clk);
    reset = 1;
    tick();
  endtask

  task automatic test_random();
    int sel;
    clear_inputs();
    reset = 0; #2; reset = 1;
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      start        = ($urandom_range(0, 7) == 0);
      stall        = ($urandom_range(0, 3) == 0);
      branch_taken = ($urandom_range(0, 3) == 0);
      sel = $urandom_range(0, 15);
      if (sel == 0)      branch_target = 32'($urandom_range(4090, 4100));
      else if (sel == 1) branch_target = $urandom;
      else               branch_target = 32'($urandom_range(0, 4095));
      instruction = ($urandom_range(0, 15) == 0) ? 9'h1FF : 9'($urandom_range(0, 510));
      #1;
      checks++; if (fetch_valid !== (m_running && !stall)) begin
        errors++; $display("FAIL rand_fv n=%0d got=%b exp=%b", n, fetch_valid, m_running && !stall);
      end
      @(posedge clk);
      model_edge();
      #1;
      checks++; if (current_pc !== m_pc) begin errors++; $display("FAIL rand_pc n=%0d got=%0h exp=%0h", n, current_pc, m_pc); end
      checks++; if (busy !== m_running) begin errors++; $display("FAIL rand_busy n=%0d got=%b exp=%b", n, busy, m_running); end
      checks++; if (done !== m_done) begin errors++; $display("FAIL rand_done n=%0d got=%b exp=%b", n, done, m_done); end
      checks++; if (fault !== m_faulted) begin errors++; $display("FAIL rand_fault n=%0d got=%b exp=%b", n, fault, m_faulted); end
`ifdef FETCH_PERF_COUNT_EN
      checks++; if (cycle_count !== 32'(m_cyc) || retired_count !== 32'(m_ret)) begin
        errors++; $display("FAIL rand_perf n=%0d cyc=%0d ret=%0d exp %0d %0d", n, cycle_count, retired_count, m_cyc, m_ret);
      end
`endif
    end
    clear_inputs();
  endtask

  initial begin
    #1;
    test_reset();
    test_increment();
    test_branch();
    test_stall();
    test_halt();
    test_fault();
    test_reset_midrun();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
